// File: rtl/e203_exu_longp_wbck_src_if.sv
// Long-pipe writeback bus towards the final writeback arbiter.
//   valid  - writeback request (driven by the source)
//   ready  - arbiter accepts the writeback
//   wdat   - writeback data, FLEN wide
//   flags  - writeback flags (5 bits)
//   rdidx  - destination register index
// master: the long-pipe writeback source; slave: the arbiter.
interface e203_exu_longp_wbck_src_if #(
    parameter int unsigned FLEN    = 32,
    parameter int unsigned RFIDX_W = 5
);
    logic               valid;
    logic               ready;
    logic [FLEN-1:0]    wdat;
    logic [4:0]         flags;
    logic [RFIDX_W-1:0] rdidx;

    modport master (output valid, wdat, flags, rdidx, input ready);
    modport slave  (input valid, wdat, flags, rdidx, output ready);
endinterface

// File: rtl/e203_exu_longp_wbck_src.sv
// Long-pipe writeback source.
// Keeps an in-order outstanding-instruction FIFO (OITF) of {rdwen, rdidx}
// allocated at dispatch, accepts LSU / MulDiv results only for the FIFO
// head, and registers the retired result into a single output stage.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   disp_*                   - dispatch allocation (valid/ready, rdwen, rdidx, itag)
//   oitf_empty               - no outstanding entries
//   lsu_wbck_*, mdv_wbck_*   - result sources (valid/ready, itag, wdat)
//   longp_wbck_o             - registered writeback bus (master modport)
module e203_exu_longp_wbck_src #(
    parameter int unsigned OITF_DEPTH = 2,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FLEN       = 32,
    parameter int unsigned RFIDX_W    = 5,
    parameter int unsigned ITAG_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic                 disp_rdwen,
    input  logic [RFIDX_W-1:0]   disp_rdidx,
    output logic [ITAG_W-1:0]    disp_itag,
    output logic                 oitf_empty,

    input  logic                 lsu_wbck_valid,
    output logic                 lsu_wbck_ready,
    input  logic [ITAG_W-1:0]    lsu_wbck_itag,
    input  logic [XLEN-1:0]      lsu_wbck_wdat,

    input  logic                 mdv_wbck_valid,
    output logic                 mdv_wbck_ready,
    input  logic [ITAG_W-1:0]    mdv_wbck_itag,
    input  logic [XLEN-1:0]      mdv_wbck_wdat,

    e203_exu_longp_wbck_src_if.master longp_wbck_o
);

    localparam logic [ITAG_W:0] PTR_ONE = (ITAG_W+1)'(1);

    // Pointers carry an extra wrap bit above the index bits.
    logic [ITAG_W:0]      wr_ptr;
    logic [ITAG_W:0]      rd_ptr;
    logic [ITAG_W-1:0]    wr_idx;
    logic [ITAG_W-1:0]    rd_idx;

    logic [OITF_DEPTH-1:0] ent_rdwen;
    logic [RFIDX_W-1:0]    ent_rdidx [OITF_DEPTH];

    logic                 empty;
    logic                 full;
    logic                 alloc;
    logic                 lsu_hit;
    logic                 mdv_hit;
    logic                 stage_en;
    logic                 ret;
    logic [FLEN-1:0]      ret_wdat;

    logic                 out_valid;
    logic [FLEN-1:0]      out_wdat;
    logic [RFIDX_W-1:0]   out_rdidx;

    assign wr_idx = wr_ptr[ITAG_W-1:0];
    assign rd_idx = rd_ptr[ITAG_W-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[ITAG_W] != rd_ptr[ITAG_W]);

    assign disp_ready = ~full;
    assign disp_itag  = wr_idx;
    assign oitf_empty = empty;
    assign alloc      = disp_valid & ~full;

    // Only the FIFO head may retire; other results stall at their source.
    assign lsu_hit  = lsu_wbck_valid & ~empty & (lsu_wbck_itag == rd_idx);
    assign mdv_hit  = mdv_wbck_valid & ~empty & (mdv_wbck_itag == rd_idx);
    assign stage_en = ~out_valid | longp_wbck_o.ready;

    assign lsu_wbck_ready = lsu_hit & stage_en;
    assign mdv_wbck_ready = mdv_hit & ~lsu_hit & stage_en;
    assign ret            = lsu_wbck_ready | mdv_wbck_ready;

    assign ret_wdat = lsu_hit ? FLEN'(lsu_wbck_wdat) : FLEN'(mdv_wbck_wdat);

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_rdwen[wr_idx] <= disp_rdwen;
            ent_rdidx[wr_idx] <= disp_rdidx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_wdat  <= '0;
            out_rdidx <= '0;
        end else begin
            if (alloc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ret) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                // rdwen=0 entries retire silently: data loads, no valid pulse.
                out_valid <= ent_rdwen[rd_idx];
                out_wdat  <= ret_wdat;
                out_rdidx <= ent_rdidx[rd_idx];
            end else if (stage_en) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign longp_wbck_o.valid = out_valid;
    assign longp_wbck_o.wdat  = out_wdat;
    assign longp_wbck_o.rdidx = out_rdidx;
    // Integer sources never raise FP exception flags.
    assign longp_wbck_o.flags = '0;

endmodule
